deserializer_queue_top: RTL and testbench

Serial-to-parallel front end feeding an 8-entry byte FIFO. Serial bits qualified by `write_in` are assembled into bytes. Each completed byte is held until the host grants `enqueue_in`, then pushed into the FIFO. The host pops bytes with `dequeue_in`. This is the top-level integration block of the deserializer/queue datapath.

---
 rtl/deserializer_queue_pkg.sv | 10 +
 rtl/deserializer.sv | 58 +++++
 rtl/deserializer_queue_top.sv | 58 +++++
 tb/tb_deserializer_queue_top.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/deserializer_queue_pkg.sv
// deserializer_queue_pkg: shared widths, byte type and deserializer state encoding
package deserializer_queue_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int LEN_W      = $clog2(DEPTH + 1);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DATA_WIDTH);
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic {COLLECT, HOLD} deser_state_t;
endpackage

// File: rtl/deserializer.sv
// deserializer: assembles qualified serial bits into a byte and holds it until acked (DESER_LSB_FIRST_EN selects LSB-first)
module deserializer
    import deserializer_queue_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  write_in,
    input  logic                  ack_in,
    output logic [DATA_WIDTH-1:0] byte_out,
    output logic                  data_ready,
    output logic                  status_out
);
    deser_state_t     state, state_n;
    logic [CNT_W-1:0] cnt;
    data_t            sr, shifted;
    logic             take;

    assign take = (state == COLLECT) && write_in;
`ifdef DESER_LSB_FIRST_EN
    assign shifted = {data_in, sr[DATA_WIDTH-1:1]};
`else
    assign shifted = {sr[DATA_WIDTH-2:0], data_in};
`endif
    assign byte_out   = sr;
    assign data_ready = (state == HOLD);
    assign status_out = (state == HOLD);

    // next state: last bit of a byte enters HOLD, an accepted push releases it
    always_comb begin
        state_n = state;
        if (take && cnt == CNT_W'(DATA_WIDTH - 1))
            state_n = HOLD;
        else if (state == HOLD && ack_in)
            state_n = COLLECT;
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= COLLECT;
        else
            state <= state_n;
    end

    // shift register and bit counter; bits arriving in HOLD are dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (take) begin
            sr  <= shifted;
            cnt <= cnt + 1'b1;
        end else if (state == HOLD && ack_in) begin
            cnt <= '0;
        end
    end
endmodule

// File: rtl/deserializer_queue_top.sv
// deserializer_queue_top: serial deserializer feeding an 8-entry circular byte FIFO
module deserializer_queue_top
    import deserializer_queue_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  write_in,
    input  logic                  enqueue_in,
    input  logic                  dequeue_in,
    output logic                  data_ready,
    output logic                  status_out,
    output logic [LEN_W-1:0]      len_out,
    output logic [DATA_WIDTH-1:0] data_out
);
    data_t            mem [DEPTH];
    data_t            held;
    logic [PTR_W-1:0] head, tail;
    logic             push, pop;

    assign push = data_ready && enqueue_in && (len_out != LEN_W'(DEPTH));
    assign pop  = dequeue_in && (len_out != '0);

    deserializer u_deser (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .ack_in     (push),
        .byte_out   (held),
        .data_ready (data_ready),
        .status_out (status_out)
    );

    // storage is intentionally not reset; occupancy alone defines validity
    always_ff @(posedge clock) begin
        if (push)
            mem[tail] <= held;
    end

    // pointers, occupancy and registered pop data; push and pop judged on start-of-cycle occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            len_out  <= '0;
            data_out <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop) begin
                head     <= head + 1'b1;
                data_out <= mem[head];
            end
            len_out <= len_out + LEN_W'(push) - LEN_W'(pop);
        end
    end
endmodule

// File: tb/tb_deserializer_queue_top.sv
// tb_deserializer_queue_top: scoreboard bench with a queue-based reference model (honours DESER_LSB_FIRST_EN)
module tb_deserializer_queue_top;
    logic       clock = 0, reset = 0;
    logic       data_in = 0, write_in = 0, enqueue_in = 0, dequeue_in = 0;
    logic       data_ready, status_out;
    logic [3:0] len_out;
    logic [7:0] data_out;

    deserializer_queue_top dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .enqueue_in (enqueue_in),
        .dequeue_in (dequeue_in),
        .data_ready (data_ready),
        .status_out (status_out),
        .len_out    (len_out),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] len;
        logic       rdy;
        logic [7:0] dout;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] mq[$];
    logic       held = 0;
    logic [7:0] hb = 0, acc = 0, dout = 0;
    int         nb = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic cyc(input logic w, input logic d, input logic e, input logic dq);
        exp_t x;
        int   n;
        @(negedge clock);
        write_in = w; data_in = d; enqueue_in = e; dequeue_in = dq;
        n = mq.size();
        if (dq && n > 0) dout = mq.pop_front();
        if (held && e && n < 8) begin
            mq.push_back(hb);
            held = 0;
        end else if (!held && w) begin
`ifdef DESER_LSB_FIRST_EN
            acc[nb] = d;
`else
            acc[7-nb] = d;
`endif
            nb++;
            if (nb == 8) begin
                held = 1;
                hb = acc;
                nb = 0;
            end
        end
        x.len = 4'(mq.size()); x.rdy = held; x.dout = dout;
        exp_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
`ifdef DESER_LSB_FIRST_EN
            b = v[i];
`else
            b = v[7-i];
`endif
            cyc(1, b, 0, 0);
        end
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_len"}, 32'(len_out), 0);
        chk({nm, "_ready"}, 32'(data_ready), 0);
        chk({nm, "_busy"}, 32'(status_out), 0);
        chk({nm, "_dout"}, 32'(data_out), 0);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("mon_len", 32'(len_out), 32'(x.len));
                chk("mon_ready", 32'(data_ready), 32'(x.rdy));
                chk("mon_busy", 32'(status_out), 32'(x.rdy));
                chk("mon_dout", 32'(data_out), 32'(x.dout));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clock);
        chk_zero("por");
        reset = 1;
        send_byte(8'hA5);
        settle();
        chk("a5_ready", 32'(data_ready), 1);
        chk("a5_busy", 32'(status_out), 1);
        cyc(0, 0, 1, 0);
        settle();
        chk("a5_len", 32'(len_out), 1);
        chk("a5_ready_low", 32'(data_ready), 0);
        cyc(0, 0, 0, 1);
        settle();
        chk("a5_dout", 32'(data_out), 32'h A5);
        chk("a5_len0", 32'(len_out), 0);
        for (int v = 1; v <= 8; v++) begin
            send_byte(8'(v));
            cyc(0, 0, 1, 0);
        end
        settle();
        chk("full_len", 32'(len_out), 8);
        send_byte(8'hFF);
        repeat (3) cyc(1, 1'($urandom), 1, 0);
        settle();
        chk("full_held", 32'(data_ready), 1);
        chk("full_len_hold", 32'(len_out), 8);
        cyc(0, 0, 0, 1);
        settle();
        chk("first_out", 32'(data_out), 1);
        cyc(0, 0, 1, 0);
        settle();
        chk("refill_len", 32'(len_out), 8);
        chk("refill_ready", 32'(data_ready), 0);
        repeat (8) cyc(0, 0, 0, 1);
        settle();
        chk("drain_last", 32'(data_out), 32'h FF);
        repeat (2) cyc(0, 0, 0, 1);
        settle();
        chk("empty_pop_dout", 32'(data_out), 32'h FF);
        chk("empty_pop_len", 32'(len_out), 0);
        send_byte(8'h11); cyc(0, 0, 1, 0);
        send_byte(8'h22); cyc(0, 0, 1, 0);
        send_byte(8'h33); cyc(0, 0, 1, 0);
        send_byte(8'h44);
        cyc(0, 0, 1, 1);
        settle();
        chk("simul_len", 32'(len_out), 3);
        chk("simul_dout", 32'(data_out), 32'h 11);
        repeat (3) cyc(0, 0, 0, 1);
        for (int p = 0; p < 4; p++)
            repeat (500)
                cyc($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 9) < p * 2 + 1);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        @(negedge clock);
        #2;
        reset = 0;
        write_in = 0; data_in = 0; enqueue_in = 0; dequeue_in = 0;
        #1;
        chk_zero("async_rst");
        mq.delete();
        held = 0; nb = 0; dout = 0;
        @(negedge clock);
        reset = 1;
        cyc(0, 0, 0, 0);
        settle();
        chk("post_rst_len", 32'(len_out), 0);
        chk("post_rst_busy", 32'(status_out), 0);
        send_byte(8'($urandom));
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        repeat (3) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
